// File: rtl/hnoc_pkg.sv
// ============================================================================
// hnoc_pkg : shared flit layout, LFSR mask and generator state encoding
// Revision : 1.0
// ============================================================================
`default_nettype none

package hnoc_pkg;

  localparam int DEST_MSB = 31;
  localparam int DEST_LSB = 28;
  localparam int SRC_MSB  = 27;
  localparam int SRC_LSB  = 24;
  localparam int SEQ_MSB  = 23;
  localparam int SEQ_LSB  = 12;
  localparam int TS_MSB   = 11;
  localparam int TS_LSB   = 0;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Folds a raw 4-bit draw into the PE range, never landing on the sender.
  function automatic logic [3:0] pick_dest(input logic [3:0] raw, input int num_pe,
                                           input int addr);
    int d;
    d = int'(raw) % num_pe;
    if (d == addr) d = (d + 1) % num_pe;
    return 4'(d);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hnoc_lfsr16.sv
// ============================================================================
// hnoc_lfsr16 : 16-bit Galois LFSR with load-on-reset seed and advance enable
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hnoc_lfsr16
  import hnoc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] seed_fixed;

  // An all-zero state would lock the register forever.
  assign seed_fixed = (seed == 16'h0000) ? 16'h0001 : seed;

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= seed_fixed;
    end else if (advance) begin
      value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_MASK : 16'h0000);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pe_traffic_gen.sv
// ============================================================================
// pe_traffic_gen : per-PE single-flit packet injector with rate control,
//                  pseudo-random destinations and stall/sent statistics
// Revision       : 1.0
// ============================================================================
`default_nettype none

module pe_traffic_gen
  import hnoc_pkg::*;
#(
  parameter int          ADDRESS   = 0,
  parameter int          NUM_PE    = 16,
  parameter int          INJ_RATE  = 64,
  parameter int          MAX_PKTS  = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  output logic [31:0] o_data,
  output logic        o_data_valid,
  input  logic        i_data_ready,
  output logic [31:0] o_sent_count,
  output logic [31:0] o_stall_cycles,
  output logic        o_done
);

  localparam logic [8:0]  C_RATE    = 9'(INJ_RATE);
  localparam logic [3:0]  C_SRC     = 4'(ADDRESS);
  localparam bit          C_LIMITED = (MAX_PKTS != 0);
  localparam logic [31:0] C_MAX_M1  = 32'(MAX_PKTS - 1);

  state_t      state, next_state;
  logic [15:0] lfsr;
  logic [11:0] ts;
  logic [11:0] seq;
  logic [11:0] flit_seq;
  logic [3:0]  dest;
  logic        handshake;
  logic        hit_max;
  logic        decide;
  logic        inject;
  logic        unused_lfsr_bits;

  assign handshake = (state == SEND) && i_data_ready;
  assign hit_max   = C_LIMITED && (o_sent_count == C_MAX_M1);

  // A decision happens from IDLE, or on a handshake that does not end the run.
  assign decide = i_enable && ((state == IDLE) || (handshake && !hit_max));
  assign inject = {1'b0, lfsr[7:0]} < C_RATE;
  assign dest   = pick_dest(lfsr[15:12], NUM_PE, ADDRESS);

  // Back-to-back flits carry the sequence number after the one just accepted.
  assign flit_seq = handshake ? seq + 12'd1 : seq;

  assign unused_lfsr_bits = ^lfsr[11:8];

  hnoc_lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .seed    (LFSR_SEED),
    .advance (decide),
    .value   (lfsr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_enable && inject) next_state = SEND;
      end
      SEND: begin
        if (handshake) begin
          if (hit_max)                 next_state = DONE;
          else if (i_enable && inject) next_state = SEND;
          else                         next_state = IDLE;
        end
      end
      DONE:    next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_data_valid = (state == SEND);
    o_done       = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts             <= 12'd0;
      seq            <= 12'd0;
      o_data         <= 32'd0;
      o_sent_count   <= 32'd0;
      o_stall_cycles <= 32'd0;
    end else begin
      ts <= ts + 12'd1;
      if (handshake) begin
        seq <= seq + 12'd1;
        if (o_sent_count != 32'hFFFF_FFFF) o_sent_count <= o_sent_count + 32'd1;
      end
      if ((state == SEND) && !i_data_ready && (o_stall_cycles != 32'hFFFF_FFFF)) begin
        o_stall_cycles <= o_stall_cycles + 32'd1;
      end
      if (decide && inject) begin
        o_data[DEST_MSB:DEST_LSB] <= dest;
        o_data[SRC_MSB:SRC_LSB]   <= C_SRC;
        o_data[SEQ_MSB:SEQ_LSB]   <= flit_seq;
        o_data[TS_MSB:TS_LSB]     <= ts;
      end
    end
  end

endmodule

`default_nettype wire
